iram_dp_loader: RTL and testbench

Parametrised dual-port instruction memory for the FP51 core, the successor of the fixed 16-bit instruction RAM halves. Port A is a registered read-only fetch port. Port B is a read/write data port with byte enables. A built-in byte-stream loader assembles incoming bytes into words and writes them sequentially, for boot and debug download. Same-cycle read/write collisions forward the new data to the reader.

---
 rtl/iram_dp_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_iram_dp_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iram_dp_loader.sv
// Dual-port instruction RAM for the FP51 core: registered fetch port, byte-enabled
// data port and a byte-stream loader that owns the write port while busy.
module iram_dp_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_en,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    fetch_valid,
  input  logic                    d_en,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_rvalid,
  output logic                    d_stall,
  input  logic                    ld_start,
  input  logic [ADDR_WIDTH-1:0]   ld_base_addr,
  input  logic [7:0]              ld_byte,
  input  logic                    ld_valid,
  input  logic                    ld_last,
  output logic                    ld_ready,
  output logic                    ld_busy,
  output logic                    ld_done,
  output logic [ADDR_WIDTH:0]     ld_word_count
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(BPW - 1);

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2,
    LD_DONE    = 2'd3
  } ld_state_t;

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  ld_state_t             ld_state_r;
  logic [ADDR_WIDTH-1:0] ld_addr_r;
  logic [LANE_W-1:0]     ld_lane_r;
  logic [DATA_WIDTH-1:0] ld_buf_r;
  logic [BPW-1:0]        ld_mask_r;
  logic                  ld_last_r;
  logic                  ld_ready_r;
  logic                  ld_busy_r;
  logic                  ld_done_r;
  logic [ADDR_WIDTH:0]   ld_count_r;

  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [BPW-1:0]        wr_be_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic [DATA_WIDTH-1:0] fetch_word_s;
  logic [DATA_WIDTH-1:0] d_word_s;
  logic                  d_rd_s;

  logic                  f_valid1_r;
  logic [DATA_WIDTH-1:0] f_data1_r;
  logic                  d_valid1_r;
  logic [DATA_WIDTH-1:0] d_data1_r;

  // Post-write view of a word: enabled lanes from the new data, the rest from the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BPW-1:0]        be
  );
    logic [DATA_WIDTH-1:0] res;
    for (int i = 0; i < BPW; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  // Write-port arbitration: loader first, port B only while the loader is idle.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = ld_addr_r;
    wr_data_s = ld_buf_r;
    wr_be_s   = ld_mask_r;
    if (ld_state_r == LD_WRITE) begin
      wr_en_s = 1'b1;
    end else if (!ld_busy_r && d_en && d_we) begin
      wr_en_s   = 1'b1;
      wr_addr_s = d_addr;
      wr_data_s = d_wdata;
      wr_be_s   = d_be;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Write-first forwarding for same-cycle read/write collisions.
  always_comb begin
    wr_word_s = merge_lanes(mem_r[wr_addr_s], wr_data_s, wr_be_s);
    d_rd_s    = d_en && !d_we;
    if (wr_en_s && (fetch_addr == wr_addr_s)) begin
      fetch_word_s = wr_word_s;
    end else begin
      fetch_word_s = mem_r[fetch_addr];
    end
    if (wr_en_s && (d_addr == wr_addr_s)) begin
      d_word_s = wr_word_s;
    end else begin
      d_word_s = mem_r[d_addr];
    end
  end

  // Byte-lane memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BPW; i++) begin
      if (wr_en_s && wr_be_s[i]) begin
        mem_r[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  // First read stage for both ports; data holds between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_valid1_r <= 1'b0;
      f_data1_r  <= '0;
      d_valid1_r <= 1'b0;
      d_data1_r  <= '0;
    end else begin
      f_valid1_r <= fetch_en;
      d_valid1_r <= d_rd_s;
      if (fetch_en) begin
        f_data1_r <= fetch_word_s;
      end
      if (d_rd_s) begin
        d_data1_r <= d_word_s;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  f_valid2_r;
      logic [DATA_WIDTH-1:0] f_data2_r;
      logic                  d_valid2_r;
      logic [DATA_WIDTH-1:0] d_data2_r;

      // Output register stage; data and valid shift together.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          f_valid2_r <= 1'b0;
          f_data2_r  <= '0;
          d_valid2_r <= 1'b0;
          d_data2_r  <= '0;
        end else begin
          f_valid2_r <= f_valid1_r;
          f_data2_r  <= f_data1_r;
          d_valid2_r <= d_valid1_r;
          d_data2_r  <= d_data1_r;
        end
      end

      assign fetch_valid = f_valid2_r;
      assign fetch_data  = f_data2_r;
      assign d_rvalid    = d_valid2_r;
      assign d_rdata     = d_data2_r;
    end else begin : g_lat1
      assign fetch_valid = f_valid1_r;
      assign fetch_data  = f_data1_r;
      assign d_rvalid    = d_valid1_r;
      assign d_rdata     = d_data1_r;
    end
  endgenerate

  // Loader FSM; ready/busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_r <= LD_IDLE;
      ld_addr_r  <= '0;
      ld_lane_r  <= '0;
      ld_buf_r   <= '0;
      ld_mask_r  <= '0;
      ld_last_r  <= 1'b0;
      ld_ready_r <= 1'b0;
      ld_busy_r  <= 1'b0;
      ld_done_r  <= 1'b0;
      ld_count_r <= '0;
    end else begin
      case (ld_state_r)
        LD_IDLE: begin
          ld_done_r <= 1'b0;
          if (ld_start) begin
            ld_addr_r  <= ld_base_addr;
            ld_lane_r  <= LANE_TOP;
            ld_count_r <= '0;
            ld_buf_r   <= '0;
            ld_mask_r  <= '0;
            ld_last_r  <= 1'b0;
            ld_ready_r <= 1'b1;
            ld_busy_r  <= 1'b1;
            ld_state_r <= LD_COLLECT;
          end
        end
        LD_COLLECT: begin
          if (ld_valid) begin
            ld_buf_r[8*ld_lane_r +: 8] <= ld_byte;
            ld_mask_r[ld_lane_r]       <= 1'b1;
            ld_last_r                  <= ld_last;
            if ((ld_lane_r == '0) || ld_last) begin
              ld_ready_r <= 1'b0;
              ld_state_r <= LD_WRITE;
            end else begin
              ld_lane_r <= ld_lane_r - 1'b1;
            end
          end
        end
        LD_WRITE: begin
          ld_addr_r  <= ld_addr_r + 1'b1;
          ld_count_r <= ld_count_r + 1'b1;
          ld_lane_r  <= LANE_TOP;
          ld_mask_r  <= '0;
          if (ld_last_r) begin
            ld_done_r  <= 1'b1;
            ld_state_r <= LD_DONE;
          end else begin
            ld_ready_r <= 1'b1;
            ld_state_r <= LD_COLLECT;
          end
        end
        LD_DONE: begin
          ld_done_r  <= 1'b0;
          ld_busy_r  <= 1'b0;
          ld_state_r <= LD_IDLE;
        end
        default: begin
          ld_ready_r <= 1'b0;
          ld_busy_r  <= 1'b0;
          ld_done_r  <= 1'b0;
          ld_state_r <= LD_IDLE;
        end
      endcase
    end
  end

  assign ld_ready      = ld_ready_r;
  assign ld_busy       = ld_busy_r;
  assign ld_done       = ld_done_r;
  assign ld_word_count = ld_count_r;
  assign d_stall       = ld_busy_r;

endmodule

// File: tb/tb_iram_dp_loader.sv
// Directed self-checking bench for iram_dp_loader (latency-1 instance plus a latency-2 instance).
module tb_iram_dp_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic [11:0] fetch_addr = 12'h000;
  logic        d_en = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [11:0] d_addr = 12'h000;
  logic [31:0] d_wdata = 32'h0;
  logic        ld_start = 1'b0;
  logic [11:0] ld_base_addr = 12'h000;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_valid = 1'b0;
  logic        ld_last = 1'b0;

  logic [31:0] fetch_data, d_rdata, fetch_data2, d_rdata2;
  logic        fetch_valid, d_rvalid, d_stall, ld_ready, ld_busy, ld_done;
  logic        fetch_valid2, d_rvalid2, d_stall2, ld_ready2, ld_busy2, ld_done2;
  logic [12:0] ld_word_count, ld_word_count2;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int wr_cyc_cnt = 0;
  bit mon_en = 1'b0;

  iram_dp_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .d_en(d_en), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
    .ld_start(ld_start), .ld_base_addr(ld_base_addr), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_word_count(ld_word_count)
  );

  iram_dp_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data2), .fetch_valid(fetch_valid2),
    .d_en(d_en), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata2), .d_rvalid(d_rvalid2), .d_stall(d_stall2),
    .ld_start(ld_start), .ld_base_addr(ld_base_addr), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_ready(ld_ready2), .ld_busy(ld_busy2), .ld_done(ld_done2),
    .ld_word_count(ld_word_count2)
  );

  initial forever #5 clk = ~clk;

  // Count done pulses and WRITE cycles (busy, not ready, not done) during a load.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ld_done) done_cnt++;
      if (ld_busy && !ld_ready && !ld_done) wr_cyc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] w, input logic [3:0] be);
    d_en = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = w; d_be = be;
    tick();
    d_en = 1'b0; d_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    d_en = 1'b1; d_we = 1'b0; d_addr = a; d_be = 4'h0;
    tick();
    check({tag, "_rvalid"}, d_rvalid, 1'b1);
    check(tag, d_rdata, exp);
    d_en = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic last);
    bit taken;
    taken = 1'b0;
    ld_byte = b; ld_valid = 1'b1; ld_last = last;
    for (int k = 0; k < 8 && !taken; k++) begin
      if (ld_ready) taken = 1'b1;
      tick();
    end
    check("ld_accept", taken, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    tick(); tick();
    check("rst_fetch_valid", fetch_valid, 1'b0);
    check("rst_fetch_data", fetch_data, 32'h0);
    check("rst_d_rvalid", d_rvalid, 1'b0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_ld_flags", {ld_ready, ld_busy, ld_done, d_stall}, 4'b0000);
    check("rst_word_count", ld_word_count, 13'd0);
    reset = 1'b0;
    tick();

    // Port-B writes then fetches, including back-to-back and latency 2
    wr(12'h005, 32'h11223344, 4'hF);
    check("wr_no_rvalid", d_rvalid, 1'b0);
    wr(12'h006, 32'hA5A5A5A5, 4'hF);
    fetch_en = 1'b1; fetch_addr = 12'h005;
    tick();
    check("fetch1_valid", fetch_valid, 1'b1);
    check("fetch1_data", fetch_data, 32'h11223344);
    check("lat2_not_yet", fetch_valid2, 1'b0);
    fetch_addr = 12'h006;
    tick();
    check("fetch2_valid", fetch_valid, 1'b1);
    check("fetch2_data", fetch_data, 32'hA5A5A5A5);
    check("lat2_valid", fetch_valid2, 1'b1);
    check("lat2_data", fetch_data2, 32'h11223344);
    fetch_en = 1'b0;
    tick();
    check("fetch_idle", fetch_valid, 1'b0);
    check("lat2_data2", fetch_data2, 32'hA5A5A5A5);
    tick();
    check("lat2_idle", fetch_valid2, 1'b0);
    rd("dread_006", 12'h006, 32'hA5A5A5A5);

    // Byte-enable collision with same-cycle fetch
    wr(12'h010, 32'h00000000, 4'hF);
    d_en = 1'b1; d_we = 1'b1; d_be = 4'b0101; d_addr = 12'h010; d_wdata = 32'hAABBCCDD;
    fetch_en = 1'b1; fetch_addr = 12'h010;
    tick();
    check("coll_fetch", fetch_data, 32'h00BB00DD);
    d_en = 1'b0; d_we = 1'b0; fetch_en = 1'b0;
    rd("coll_mem", 12'h010, 32'h00BB00DD);

    // Full loader run across 0x0FF/0x100 with stalled write and ignored restart
    done_cnt = 0; wr_cyc_cnt = 0; mon_en = 1'b1;
    ld_start = 1'b1; ld_base_addr = 12'h0FF;
    tick();
    ld_start = 1'b0;
    check("ld_busy_start", ld_busy, 1'b1);
    check("ld_ready_start", ld_ready, 1'b1);
    feed(8'h01, 1'b0);
    feed(8'h02, 1'b0);
    ld_start = 1'b1; ld_base_addr = 12'h200;
    d_en = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 12'h005; d_wdata = 32'hFFFFFFFF;
    check("d_stall", d_stall, 1'b1);
    feed(8'h03, 1'b0);
    ld_start = 1'b0; d_en = 1'b0; d_we = 1'b0;
    feed(8'h04, 1'b0);
    feed(8'h05, 1'b0);
    feed(8'h06, 1'b0);
    feed(8'h07, 1'b0);
    feed(8'h08, 1'b1);
    check("ld_ready_write", ld_ready, 1'b0);
    tick();
    check("ld_done_pulse", ld_done, 1'b1);
    check("ld_busy_done", ld_busy, 1'b1);
    check("ld_count_2", ld_word_count, 13'd2);
    tick();
    check("ld_idle_flags", {ld_busy, ld_done, ld_ready}, 3'b000);
    check("ld_count_hold", ld_word_count, 13'd2);
    mon_en = 1'b0;
    check("ld_done_once", done_cnt, 1);
    check("ld_write_cycles", wr_cyc_cnt, 2);
    rd("ld_mem_0ff", 12'h0FF, 32'h01020304);
    rd("ld_mem_100", 12'h100, 32'h05060708);
    rd("stall_dropped", 12'h005, 32'h11223344);

    // Partial final word with address wrap
    wr(12'hFFF, 32'hDEADBEEF, 4'hF);
    ld_start = 1'b1; ld_base_addr = 12'hFFF;
    tick();
    ld_start = 1'b0;
    feed(8'h12, 1'b0);
    feed(8'h34, 1'b1);
    tick();
    check("wrap_done", ld_done, 1'b1);
    check("wrap_count", ld_word_count, 13'd1);
    check("wrap_addr", dut.ld_addr_r, 12'h000);
    tick();
    rd("wrap_mem", 12'hFFF, 32'h1234BEEF);

    // Asynchronous reset in the middle of a load
    ld_start = 1'b1; ld_base_addr = 12'h020;
    tick();
    ld_start = 1'b0;
    feed(8'hAA, 1'b0);
    feed(8'hBB, 1'b0);
    feed(8'hCC, 1'b0);
    feed(8'hDD, 1'b0);
    feed(8'hEE, 1'b0);
    check("pre_rst_busy", ld_busy, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("arst_ld_flags", {ld_ready, ld_busy, ld_done, d_stall}, 4'b0000);
    check("arst_count", ld_word_count, 13'd0);
    check("arst_fetch", {fetch_valid, fetch_data}, 33'h0);
    check("arst_dread", {d_rvalid, d_rdata}, 33'h0);
    check("arst_lat2", {fetch_valid2, fetch_data2}, 33'h0);
    #1 reset = 1'b0;
    tick();
    rd("arst_mem_kept", 12'h020, 32'hAABBCCDD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
